gs_row_pipe: RTL and testbench

- Parametrised, fully pipelined successor to the single-shot Gauss-Seidel row core.
- Computes one unknown per transaction: x_next = (b - sum_j a_j*x_j) * inv_diag, for N off-diagonal terms.
- Accepts one row per cycle under valid/ready handshake and flags saturation and per-row convergence for the iteration controller.

---
 rtl/gs_row_pipe.sv | 156 +++++++++++++++
 tb/tb_gs_row_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_row_pipe.sv
// Four-stage pipelined Gauss-Seidel row update: x_next = (b - sum a_j*x_j) * inv_diag.
// Single global advance enable; o_sat flags clamping and o_conv flags |x_next - x_self| <= tol.
module gs_row_pipe #(
    parameter int N          = 7,
    parameter int A_W        = 8,
    parameter int X_W        = 32,
    parameter int FRAC       = 24,
    parameter int INV_W      = 32,
    parameter int INV_FRAC   = 30,
    parameter int ROUND_MODE = 0,
    parameter int SAT_EN     = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [N*A_W-1:0]   i_a,
    input  logic [A_W-1:0]     i_b,
    input  logic [INV_W-1:0]   i_inv_diag,
    input  logic [N*X_W-1:0]   i_x,
    input  logic [X_W-1:0]     i_x_self,
    input  logic [X_W-1:0]     i_tol,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [X_W-1:0]     o_x_next,
    output logic               o_sat,
    output logic               o_conv
);
    localparam int PW = A_W + X_W;
    localparam int SW = A_W + X_W + $clog2(N + 1) + 1;
    localparam int QW = SW + INV_W;
    localparam int RW = QW - INV_FRAC;
    localparam logic signed [QW-1:0] HALF = QW'(1) <<< (INV_FRAC - 1);

    logic en;
    logic v1, v2, v3;

    logic signed [PW-1:0]    p1 [N];
    logic signed [A_W-1:0]   b1;
    logic signed [INV_W-1:0] inv1, inv2;
    logic [X_W-1:0]          xs1, xs2, xs3;
    logic [X_W-1:0]          tol1, tol2, tol3;
    logic signed [SW-1:0]    s2;
    logic signed [QW-1:0]    q3;

    logic signed [PW-1:0]    prod_c [N];
    logic signed [SW-1:0]    sum_c;
    logic signed [QW-1:0]    q_c;
    logic signed [QW-1:0]    qr_c;
    logic signed [RW-1:0]    r_c;
    logic [RW-X_W:0]         hi_c;
    logic [X_W-1:0]          x_c;
    logic                    sat_c;
    logic [X_W:0]            diff_c;
    logic [X_W:0]            mag_c;
    logic                    conv_c;

    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            prod_c[j] = $signed(i_a[(N-1-j)*A_W +: A_W]) * $signed(i_x[(N-1-j)*X_W +: X_W]);
        end
    end

    always_comb begin
        sum_c = SW'(b1) <<< FRAC;
        for (int j = 0; j < N; j++) begin
            sum_c = sum_c - SW'(p1[j]);
        end
    end

    assign q_c = QW'(s2) * QW'(inv2);

    // Legacy mode nudges every negative product up by one LSB, exact multiples included.
    always_comb begin
        qr_c = q3;
        if (ROUND_MODE == 0) begin
            r_c = RW'(q3 >>> INV_FRAC) + {{(RW-1){1'b0}}, q3[QW-1]};
        end else begin
            qr_c = q3 + HALF;
            r_c  = RW'(qr_c >>> INV_FRAC);
        end
    end

    always_comb begin
        hi_c  = r_c[RW-1:X_W-1];
        x_c   = r_c[X_W-1:0];
        sat_c = 1'b0;
        if (SAT_EN != 0) begin
            if (!r_c[RW-1] && (|hi_c)) begin
                x_c   = {1'b0, {(X_W-1){1'b1}}};
                sat_c = 1'b1;
            end else if (r_c[RW-1] && !(&hi_c)) begin
                x_c   = {1'b1, {(X_W-1){1'b0}}};
                sat_c = 1'b1;
            end
        end
        diff_c = {x_c[X_W-1], x_c} - {xs3[X_W-1], xs3};
        mag_c  = diff_c[X_W] ? (~diff_c + 1'b1) : diff_c;
        conv_c = (mag_c <= {1'b0, tol3});
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            o_valid  <= 1'b0;
            for (int j = 0; j < N; j++) p1[j] <= '0;
            b1       <= '0;
            inv1     <= '0;
            inv2     <= '0;
            xs1      <= '0;
            xs2      <= '0;
            xs3      <= '0;
            tol1     <= '0;
            tol2     <= '0;
            tol3     <= '0;
            s2       <= '0;
            q3       <= '0;
            o_x_next <= '0;
            o_sat    <= 1'b0;
            o_conv   <= 1'b0;
        end else if (en) begin
            v1      <= i_valid;
            v2      <= v1;
            v3      <= v2;
            o_valid <= v3;
            if (i_valid) begin
                p1   <= prod_c;
                b1   <= i_b;
                inv1 <= i_inv_diag;
                xs1  <= i_x_self;
                tol1 <= i_tol;
            end
            if (v1) begin
                s2   <= sum_c;
                inv2 <= inv1;
                xs2  <= xs1;
                tol2 <= tol1;
            end
            if (v2) begin
                q3   <= q_c;
                xs3  <= xs2;
                tol3 <= tol2;
            end
            if (v3) begin
                o_x_next <= x_c;
                o_sat    <= sat_c;
                o_conv   <= conv_c;
            end
        end
    end
endmodule

// File: tb/tb_gs_row_pipe.sv
// Bench for gs_row_pipe: two instances (legacy rounding + clamp, half-up rounding + wrap)
// share stimulus; results are scored against a wide-integer arithmetic model.
module tb_gs_row_pipe;
    localparam int N        = 7;
    localparam int A_W      = 8;
    localparam int X_W      = 32;
    localparam int FRAC     = 24;
    localparam int INV_W    = 32;
    localparam int INV_FRAC = 30;

    logic               i_clk;
    logic               i_reset;
    logic               i_valid;
    logic               i_ready;
    logic [N*A_W-1:0]   i_a;
    logic [A_W-1:0]     i_b;
    logic [INV_W-1:0]   i_inv_diag;
    logic [N*X_W-1:0]   i_x;
    logic [X_W-1:0]     i_x_self;
    logic [X_W-1:0]     i_tol;

    logic               o_ready0, o_valid0, o_sat0, o_conv0;
    logic [X_W-1:0]     o_x0;
    logic               o_ready1, o_valid1, o_sat1, o_conv1;
    logic [X_W-1:0]     o_x1;

    gs_row_pipe u_dut0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready0),
        .i_a(i_a), .i_b(i_b), .i_inv_diag(i_inv_diag), .i_x(i_x),
        .i_x_self(i_x_self), .i_tol(i_tol), .o_valid(o_valid0), .i_ready(i_ready),
        .o_x_next(o_x0), .o_sat(o_sat0), .o_conv(o_conv0)
    );

    gs_row_pipe #(.ROUND_MODE(1), .SAT_EN(0)) u_dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready1),
        .i_a(i_a), .i_b(i_b), .i_inv_diag(i_inv_diag), .i_x(i_x),
        .i_x_self(i_x_self), .i_tol(i_tol), .o_valid(o_valid1), .i_ready(i_ready),
        .o_x_next(o_x1), .o_sat(o_sat1), .o_conv(o_conv1)
    );

    typedef struct {
        logic [X_W-1:0] x0;
        logic           s0;
        logic           c0;
        logic [X_W-1:0] x1;
        logic           s1;
        logic           c1;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;
    logic stalled_prev = 1'b0;
    logic [X_W-1:0] px0, px1;
    logic ps0, pc0, ps1, pc1;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(
        input logic [N*A_W-1:0] a_pk, input logic [A_W-1:0] b_u,
        input logic [INV_W-1:0] inv_u, input logic [N*X_W-1:0] x_pk,
        input logic [X_W-1:0] xs_u, input logic [X_W-1:0] tol_u,
        input int rmode, input int sat_en,
        output logic [X_W-1:0] xo, output logic so, output logic co);
        logic signed [127:0] s, q, r, t, den, hi, lo, ta, tx, d, tolv;
        logic signed [A_W-1:0]   a8, b8;
        logic signed [X_W-1:0]   x32, xs32, xo32;
        logic signed [INV_W-1:0] inv32;
        b8 = b_u;
        s  = b8;
        s  = s * (128'sd1 <<< FRAC);
        for (int j = 0; j < N; j++) begin
            a8  = a_pk[(N-1-j)*A_W +: A_W];
            x32 = x_pk[(N-1-j)*X_W +: X_W];
            ta  = a8;
            tx  = x32;
            s   = s - ta * tx;
        end
        inv32 = inv_u;
        t     = inv32;
        q     = s * t;
        den   = 128'sd1 <<< INV_FRAC;
        if (rmode == 0) begin
            r = q / den;
            if (q < 0 && r * den != q) r = r - 1;
            if (q < 0) r = r + 1;
        end else begin
            t = q + den / 2;
            r = t / den;
            if (t < 0 && r * den != t) r = r - 1;
        end
        hi = (128'sd1 <<< (X_W-1)) - 1;
        lo = -(128'sd1 <<< (X_W-1));
        so = 1'b0;
        if (sat_en != 0 && r > hi) begin
            r  = hi;
            so = 1'b1;
        end else if (sat_en != 0 && r < lo) begin
            r  = lo;
            so = 1'b1;
        end
        xo   = r[X_W-1:0];
        xo32 = xo;
        xs32 = xs_u;
        d    = xo32;
        t    = xs32;
        d    = d - t;
        if (d < 0) d = -d;
        tolv = tol_u;
        co   = (d <= tolv);
    endfunction

    // One clock: drive at negedge, sample 1 ns later, score, then wait for next negedge.
    task automatic cycle(input logic v, input logic r, output logic acc);
        exp_t e;
        i_valid = v;
        i_ready = r;
        #1;
        acc = v && o_ready0;
        chk("o_ready", o_ready0, !o_valid0 || r);
        chk("o_valid_pair", o_valid1, o_valid0);
        if (stalled_prev) begin
            chk("stall_valid", o_valid0, 1);
            chk("stall_x0", o_x0, px0);
            chk("stall_x1", o_x1, px1);
            chk("stall_flags", {ps0, pc0, ps1, pc1}, {o_sat0, o_conv0, o_sat1, o_conv1});
        end
        if (o_valid0 && r) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_out++;
                chk("x0", o_x0, e.x0);
                chk("sat0", o_sat0, e.s0);
                chk("conv0", o_conv0, e.c0);
                chk("x1", o_x1, e.x1);
                chk("sat1", o_sat1, e.s1);
                chk("conv1", o_conv1, e.c1);
            end
        end
        if (acc) begin
            model(i_a, i_b, i_inv_diag, i_x, i_x_self, i_tol, 0, 1, e.x0, e.s0, e.c0);
            model(i_a, i_b, i_inv_diag, i_x, i_x_self, i_tol, 1, 0, e.x1, e.s1, e.c1);
            sb.push_back(e);
        end
        stalled_prev = o_valid0 && !r;
        px0 = o_x0; ps0 = o_sat0; pc0 = o_conv0;
        px1 = o_x1; ps1 = o_sat1; pc1 = o_conv1;
        @(negedge i_clk);
    endtask

    task automatic rand_row();
        logic [31:0] t;
        for (int j = 0; j < N; j++) i_a[j*A_W +: A_W] = A_W'($urandom);
        for (int j = 0; j < N; j++) begin
            t = $urandom;
            if ($urandom_range(0, 1) == 1) t = {{6{t[25]}}, t[25:0]};
            i_x[j*X_W +: X_W] = t;
        end
        i_b = A_W'($urandom);
        t = $urandom;
        i_inv_diag = ($urandom_range(0, 2) == 0) ? t : {{3{t[28]}}, t[28:0]};
        t = $urandom;
        i_x_self = ($urandom_range(0, 1) == 1) ? t : {{6{t[25]}}, t[25:0]};
        t = $urandom;
        i_tol = ($urandom_range(0, 3) == 0) ? t : {12'b0, t[19:0]};
    endtask

    task automatic directed(input logic [N*A_W-1:0] a, input logic [A_W-1:0] b,
                            input logic [INV_W-1:0] inv, input logic [N*X_W-1:0] x,
                            input logic [X_W-1:0] xs, input logic [X_W-1:0] tol,
                            input logic [X_W-1:0] e0, input logic es0, input logic ec0,
                            input logic [X_W-1:0] e1, input logic es1, input logic ec1);
        logic acc;
        i_a = a; i_b = b; i_inv_diag = inv; i_x = x; i_x_self = xs; i_tol = tol;
        cycle(1'b1, 1'b1, acc);
        chk("dir_accept", acc, 1);
        for (int k = 0; k < 3; k++) begin
            chk("dir_latency_early", o_valid0, 0);
            cycle(1'b0, 1'b1, acc);
        end
        chk("dir_latency_valid", o_valid0, 1);
        chk("dir_x0", o_x0, e0);
        chk("dir_flags0", {o_sat0, o_conv0}, {es0, ec0});
        chk("dir_x1", o_x1, e1);
        chk("dir_flags1", {o_sat1, o_conv1}, {es1, ec1});
        cycle(1'b0, 1'b1, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int k = 0; k < 60 && sb.size() > 0; k++) cycle(1'b0, 1'b1, acc);
        chk("drained", sb.size(), 0);
    endtask

    initial begin
        logic acc;
        int   base;
        i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_a = '0; i_b = '0; i_inv_diag = '0; i_x = '0; i_x_self = '0; i_tol = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_valid", {o_valid0, o_valid1}, 0);
        chk("rst_x", {o_x0, o_x1}, 0);
        chk("rst_flags", {o_sat0, o_conv0, o_sat1, o_conv1}, 0);
        i_reset = 1'b1;
        #1;
        chk("rst_ready", o_ready0, 1);
        @(negedge i_clk);

        directed('0, 8'd1, 32'h4000_0000, '0, '0, '0,
                 32'h0100_0000, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        directed('0, 8'hFF, 32'h4000_0000, '0, '0, '0,
                 32'hFF00_0001, 1'b0, 1'b0, 32'hFF00_0000, 1'b0, 1'b0);
        directed({8'd2, {((N-1)*A_W){1'b0}}}, 8'd4, 32'h1000_0000,
                 {32'h0080_0000, {((N-1)*X_W){1'b0}}}, 32'h00C0_0000, '0,
                 32'h00C0_0000, 1'b0, 1'b1, 32'h00C0_0000, 1'b0, 1'b1);
        directed('0, 8'd127, 32'h7FFF_FFFF, '0, '0, '0,
                 32'h7FFF_FFFF, 1'b1, 1'b0, 32'hFDFF_FFFE, 1'b0, 1'b0);

        base = n_out;
        for (int i = 0; i < 10; i++) begin
            rand_row();
            if (i == 6) begin
                for (int k = 0; k < 3; k++) begin
                    cycle(1'b1, 1'b0, acc);
                    chk("stall_no_accept", acc, 0);
                end
            end
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) cycle(1'b1, 1'b1, acc);
            chk("stream_accept", acc, 1);
        end
        drain();
        chk("stream_count", n_out - base, 10);

        for (int i = 0; i < 300; i++) begin
            rand_row();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc);
        end
        drain();

        for (int i = 0; i < 4; i++) begin
            rand_row();
            cycle(1'b1, 1'b1, acc);
            chk("pre_rst_accept", acc, 1);
        end
        chk("pre_rst_valid", o_valid0, 1);
        i_reset = 1'b0;
        cycle(1'b0, 1'b0, acc);
        chk("midrst_valid", {o_valid0, o_valid1}, 0);
        chk("midrst_x", {o_x0, o_x1}, 0);
        chk("midrst_flags", {o_sat0, o_conv0, o_sat1, o_conv1}, 0);
        sb.delete();
        stalled_prev = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("post_rst_ready", o_ready0, 1);
        for (int k = 0; k < 8; k++) begin
            chk("no_stale", o_valid0, 0);
            cycle(1'b0, 1'b1, acc);
        end

        for (int i = 0; i < 20; i++) begin
            rand_row();
            cycle(1'b1, 1'b1, acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
